// File: rtl/ldtu_out_stage_if.sv
// Bus bundle between the control unit, the output stage and the serializer lanes.
// The master side drives mode, write and flush requests; the slave side is the output stage.
interface ldtu_out_stage_if #(
    parameter int NBITS    = 32,
    parameter int NLANES   = 4,
    parameter int PTR_BITS = 4
);
    logic [1:0]              MODE;
    logic                    wr_en;
    logic [NBITS-1:0]        data_in;
    logic                    handshake;
    logic [NLANES*NBITS-1:0] atu_data;
    logic [NLANES*NBITS-1:0] data_out;
    logic                    full;
    logic                    empty;
    logic                    losing_data;
    logic [7:0]              drop_cnt;
    logic [PTR_BITS:0]       level;

    modport master (
        output MODE, wr_en, data_in, handshake, atu_data,
        input  data_out, full, empty, losing_data, drop_cnt, level
    );

    modport slave (
        input  MODE, wr_en, data_in, handshake, atu_data,
        output data_out, full, empty, losing_data, drop_cnt, level
    );
endinterface

// File: rtl/ldtu_out_stage.sv
// LiTE-DTU output stage: circular word buffer feeding NLANES serializer lanes round-robin,
// with ATU pass-through, sync/idle patterns, handshake flush and dropped-write accounting.
module ldtu_out_stage #(
    parameter int               NBITS     = 32,
    parameter int               NLANES    = 4,
    parameter int               DEPTH     = 16,
    parameter int               PTR_BITS  = 4,
    parameter logic [NBITS-1:0] IDLE_WORD = 32'hEAAAAAAA,
    parameter logic [NBITS-1:0] SYNC_WORD = 32'h5A5A5A5A
) (
    input  logic                CLK,
    input  logic                RST,
    ldtu_out_stage_if.slave     bus
);
    localparam int                LANE_BITS = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [PTR_BITS:0] FULL_CNT  = (PTR_BITS+1)'(DEPTH);
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NLANES - 1);

    localparam logic [1:0] MODE_DTU  = 2'b00;
    localparam logic [1:0] MODE_ATU  = 2'b01;
    localparam logic [1:0] MODE_SYNC = 2'b10;
    localparam logic [1:0] MODE_IDLE = 2'b11;

    logic [NBITS-1:0]        mem [DEPTH];
    logic [PTR_BITS-1:0]     wr_ptr, rd_ptr;
    logic [PTR_BITS:0]       count, count_next;
    logic                    full_q, empty_q;
    logic [LANE_BITS-1:0]    lane_ptr;
    logic [NLANES*NBITS-1:0] lanes;
    logic                    lose_q;
    logic [7:0]              drops;

    logic do_wr, do_drop, do_rd;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        do_wr      = 1'b0;
        do_drop    = 1'b0;
        do_rd      = 1'b0;
        count_next = count;
        if (!bus.handshake) begin
            do_wr   = bus.wr_en && !full_q;
            do_drop = bus.wr_en && full_q;
            do_rd   = (bus.MODE == MODE_DTU) && !empty_q;
            if (do_wr && !do_rd)
                count_next = count + (PTR_BITS+1)'(1);
            else if (!do_wr && do_rd)
                count_next = count - (PTR_BITS+1)'(1);
        end else begin
            count_next = '0;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge CLK) begin
        if (do_wr)
            mem[wr_ptr] <= bus.data_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            lane_ptr <= '0;
            lanes    <= '0;
            lose_q   <= 1'b0;
            drops    <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (bus.handshake)
                rd_ptr <= wr_ptr;
            else if (do_rd)
                rd_ptr <= rd_ptr + PTR_BITS'(1);

            count   <= count_next;
            full_q  <= (count_next == FULL_CNT);
            empty_q <= (count_next == '0);

            lose_q <= do_drop;
            if (do_drop && drops != 8'hFF)
                drops <= drops + 8'd1;

            if (bus.handshake) begin
                lanes    <= {NLANES{SYNC_WORD}};
                lane_ptr <= '0;
            end else begin
                case (bus.MODE)
                    MODE_DTU: begin
                        // Only the scheduled lane changes; the rest hold for a full rotation.
                        lanes[int'(lane_ptr)*NBITS +: NBITS] <= empty_q ? IDLE_WORD : mem[rd_ptr];
                        lane_ptr <= (lane_ptr == LAST_LANE) ? '0 : lane_ptr + LANE_BITS'(1);
                    end
                    MODE_ATU: begin
                        lanes <= bus.atu_data;
                    end
                    MODE_SYNC: begin
                        lanes    <= {NLANES{SYNC_WORD}};
                        lane_ptr <= '0;
                    end
                    default: begin
                        lanes    <= {NLANES{IDLE_WORD}};
                        lane_ptr <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out    = lanes;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.losing_data = lose_q;
    assign bus.drop_cnt    = drops;
    assign bus.level       = count;
endmodule
